nbb_uart_tx: RTL and testbench

Memory-mapped UART transmitter on the NBBPU data bus, in parallel with the data RAM, driven by the same select/read_enable/write_enable/address/write_data signals. Software writes bytes into an 8-entry FIFO. A serialiser shifts each byte out on tx as 8N1 at a programmable baud divisor. Status and divisor are readable over read_data, so firmware can print over a pin instead of only the RGB debug LEDs.

---
 rtl/nbb_bus_pkg.sv | 27 ++
 rtl/nbb_uart_tx_sync_fifo.sv | 51 +++++
 rtl/nbb_uart_tx.sv | 134 +++++++++++++
 tb/tb_nbb_uart_tx.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nbb_bus_pkg.sv
// nbb_bus_pkg: shared NBBPU bus constants, UART register map and serialiser state encoding.
package nbb_bus_pkg;

    localparam logic [15:0] UART_BASE = 16'hFF00;

    localparam logic [1:0] OFF_DATA    = 2'd0;
    localparam logic [1:0] OFF_STATUS  = 2'd1;
    localparam logic [1:0] OFF_DIVISOR = 2'd2;

    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_BUSY    = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    function automatic logic [15:0] eff_div(input logic [15:0] div);
        return (div == 16'd0) ? 16'd1 : div;
    endfunction

endpackage

// File: rtl/nbb_uart_tx_sync_fifo.sv
// sync_fifo: single-clock FIFO with first-word-fall-through output.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       data_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok, pop_ok;

    // Full/empty use the pre-edge count, so a push into a full FIFO is dropped even alongside a pop.
    assign full_o  = count_q == DEPTH[AW:0];
    assign empty_o = count_q == '0;
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end

    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end

    always_ff @(posedge clk_i)
        if (push_ok) mem_q[wr_ptr_q] <= data_i;

endmodule

// File: rtl/nbb_uart_tx.sv
// nbb_uart_tx: memory-mapped 8N1 UART transmitter with an 8-entry TX FIFO on the NBBPU data bus.
module nbb_uart_tx
    import nbb_bus_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR       = UART_BASE,
    parameter int          FIFO_DEPTH      = 8,
    parameter logic [15:0] DEFAULT_DIVISOR = 16'd104
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        select_i,
    input  logic        read_enable_i,
    input  logic        write_enable_i,
    input  logic [15:0] address_i,
    input  logic [15:0] write_data_i,
    output logic [15:0] read_data_o,
    output logic        tx_o,
    output logic        irq_o
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    uart_state_e   state_q, state_d;
    logic [15:0]   baud_q, baud_d, div_q, div_d, divisor_q, divisor_d, rdata_q, rdata_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          ovf_q, ovf_d, tx_q, tx_d, irq_q, irq_d;
    logic [15:0]   offset, status;
    logic [1:0]    reg_sel;
    logic          in_win, wr_acc, rd_acc, push, pop, bit_end;
    logic          fifo_full, fifo_empty;
    logic [7:0]    fifo_dout;
    logic [CW-1:0] fifo_count;

    assign offset  = address_i - BASE_ADDR;
    assign in_win  = offset < 16'd4;
    assign reg_sel = offset[1:0];
    assign wr_acc  = select_i & write_enable_i & in_win;
    assign rd_acc  = select_i & read_enable_i & in_win;
    assign push    = wr_acc & (reg_sel == OFF_DATA);
    assign bit_end = baud_q == div_q - 16'd1;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .data_i  (write_data_i[7:0]),
        .pop_i   (pop),
        .data_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        status             = '0;
        status[ST_FULL]    = fifo_full;
        status[ST_EMPTY]   = fifo_empty;
        status[ST_BUSY]    = state_q != IDLE;
        status[ST_OVF]     = ovf_q;
        status[ST_CNT_LSB +: 4] = 4'(fifo_count);
    end

    always_comb begin
        divisor_d = (wr_acc && reg_sel == OFF_DIVISOR) ? write_data_i : divisor_q;
        ovf_d     = (push && fifo_full) ? 1'b1 : (rd_acc && reg_sel == OFF_STATUS) ? 1'b0 : ovf_q;
        rdata_d   = !read_enable_i ? rdata_q :
                    !rd_acc ? 16'h0000 :
                    (reg_sel == OFF_STATUS) ? status :
                    (reg_sel == OFF_DIVISOR) ? divisor_q : 16'h0000;
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        div_d   = div_q;
        pop     = 1'b0;
        if (state_q != IDLE) baud_d = bit_end ? '0 : baud_q + 16'd1;
        case (state_q)
            IDLE:
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_dout;
                    div_d   = eff_div(divisor_q);
                    state_d = START;
                end
            START: if (bit_end) state_d = DATA;
            DATA:
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = STOP;
                end
            STOP: if (bit_end) state_d = IDLE;
        endcase
    end

    // Pin outputs follow the current state one edge later, keeping bus inputs off the pin path.
    always_comb begin
        tx_d  = (state_q == START) ? 1'b0 : (state_q == DATA) ? shift_q[0] : 1'b1;
        irq_d = (state_q == IDLE) && (state_d == IDLE) && !push;
    end

    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            div_q     <= 16'd1;
            divisor_q <= DEFAULT_DIVISOR;
            ovf_q     <= 1'b0;
            rdata_q   <= '0;
            tx_q      <= 1'b1;
            irq_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            div_q     <= div_d;
            divisor_q <= divisor_d;
            ovf_q     <= ovf_d;
            rdata_q   <= rdata_d;
            tx_q      <= tx_d;
            irq_q     <= irq_d;
        end

    assign read_data_o = rdata_q;
    assign tx_o        = tx_q;
    assign irq_o       = irq_q;

endmodule

// File: tb/tb_nbb_uart_tx.sv
// tb_nbb_uart_tx: register-map vector table plus directed frame sequences checked by a serial-line monitor.
module tb_nbb_uart_tx;

    typedef struct {
        logic        wr;
        logic        sel;
        logic [15:0] addr;
        logic [15:0] data;
        logic [15:0] exp;
    } vec_t;

    typedef struct {
        logic [7:0] b;
        int         d;
    } frm_t;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        select_i = 1'b0;
    logic        read_enable_i = 1'b0;
    logic        write_enable_i = 1'b0;
    logic [15:0] address_i = '0;
    logic [15:0] write_data_i = '0;
    logic [15:0] read_data_o;
    logic        tx_o;
    logic        irq_o;

    frm_t exp_q[$];
    int   start_q[$];
    int   vecs = 0;
    int   errs = 0;
    int   cyc = 0;
    logic mon_busy = 1'b0;

    nbb_uart_tx dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .select_i       (select_i),
        .read_enable_i  (read_enable_i),
        .write_enable_i (write_enable_i),
        .address_i      (address_i),
        .write_data_i   (write_data_i),
        .read_data_o    (read_data_o),
        .tx_o           (tx_o),
        .irq_o          (irq_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic bus(input logic wr, input logic sel, input logic [15:0] a, input logic [15:0] d);
        select_i       = sel;
        write_enable_i = wr;
        read_enable_i  = !wr;
        address_i      = a;
        write_data_i   = d;
        tick;
        select_i       = 1'b0;
        write_enable_i = 1'b0;
        read_enable_i  = 1'b0;
    endtask

    task automatic expect_frame(input logic [7:0] b, input int d);
        frm_t f;
        f.b = b;
        f.d = d;
        exp_q.push_back(f);
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) tick;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || mon_busy) && n < 3000) begin
            tick;
            n++;
        end
        vecs++;
        if (n >= 3000) begin
            errs++;
            $display("FAIL %s_drain: %0d frames pending after %0d cycles, want 0", name, exp_q.size(), n);
        end
    endtask

    task automatic chk_gaps(input string name, input int n, input int gap);
        int bad = 0;
        chk({name, "_frames"}, 16'(start_q.size()), 16'(n));
        for (int i = 1; i < start_q.size(); i++)
            if (start_q[i] - start_q[i-1] != gap) bad++;
        chk({name, "_gaps"}, 16'(bad), 16'h0000);
    endtask

    // Serial-line monitor: every low on tx must start a queued frame, checked cycle by cycle.
    initial begin : monitor
        frm_t e;
        int   s, k, bi;
        logic bad, bv, want, abort;
        forever begin
            tick;
            if (rst_ni && tx_o === 1'b0) begin
                if (exp_q.size() == 0) begin
                    vecs++;
                    errs++;
                    $display("FAIL unexpected_frame: tx low at cycle %0d, want idle high", cyc);
                    while (tx_o !== 1'b1) tick;
                end else begin
                    e = exp_q.pop_front();
                    mon_busy = 1'b1;
                    s = cyc; bad = 1'b0; abort = 1'b0; bi = 0; bv = 1'b0;
                    for (int i = 0; i < 10 * e.d; i++) begin
                        if (i > 0) tick;
                        if (!rst_ni) begin
                            abort = 1'b1;
                            break;
                        end
                        k = i / e.d;
                        want = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : e.b[k-1];
                        if (tx_o !== want && !bad) begin
                            bad = 1'b1; bi = i; bv = tx_o;
                        end
                    end
                    if (!abort) begin
                        vecs++;
                        start_q.push_back(s);
                        if (bad) begin
                            errs++;
                            $display("FAIL frame_%h_d%0d: tx=%b at sample %0d, want %b", e.b, e.d, bv, bi,
                                     (bi / e.d == 0) ? 1'b0 : (bi / e.d == 9) ? 1'b1 : e.b[bi / e.d - 1]);
                        end
                    end
                    mon_busy = 1'b0;
                end
            end
        end
    end

    initial begin : main
        vec_t tbl[20];
        int   c0, lat;
        tbl = '{
            '{1'b0, 1'b1, 16'hFF02, 16'h0000, 16'h0068},
            '{1'b0, 1'b1, 16'hFF01, 16'h0000, 16'h0002},
            '{1'b1, 1'b1, 16'hFF02, 16'h1234, 16'h0002},
            '{1'b0, 1'b1, 16'hFF02, 16'h0000, 16'h1234},
            '{1'b0, 1'b1, 16'hFF03, 16'h0000, 16'h0000},
            '{1'b0, 1'b1, 16'hFF02, 16'h0000, 16'h1234},
            '{1'b0, 1'b1, 16'hFF00, 16'h0000, 16'h0000},
            '{1'b0, 1'b1, 16'hFF02, 16'h0000, 16'h1234},
            '{1'b0, 1'b1, 16'hFEFF, 16'h0000, 16'h0000},
            '{1'b1, 1'b1, 16'hFF03, 16'hFFFF, 16'h0000},
            '{1'b1, 1'b1, 16'hFF04, 16'h0055, 16'h0000},
            '{1'b1, 1'b0, 16'hFF02, 16'h0077, 16'h0000},
            '{1'b0, 1'b1, 16'hFF02, 16'h0000, 16'h1234},
            '{1'b0, 1'b0, 16'hFF02, 16'h0000, 16'h0000},
            '{1'b1, 1'b1, 16'hFF02, 16'h0000, 16'h0000},
            '{1'b0, 1'b1, 16'hFF01, 16'h0000, 16'h0002},
            '{1'b0, 1'b1, 16'hFF02, 16'h0000, 16'h0000},
            '{1'b1, 1'b1, 16'hFF02, 16'h0004, 16'h0000},
            '{1'b0, 1'b1, 16'hFF02, 16'h0000, 16'h0004},
            '{1'b0, 1'b1, 16'hFF04, 16'h0000, 16'h0000}
        };

        // Reset held low while the bus is hammered.
        for (int i = 0; i < 6; i++) begin
            select_i       = 1'($urandom);
            read_enable_i  = 1'($urandom);
            write_enable_i = 1'($urandom);
            address_i      = 16'hFF00 | 16'($urandom_range(0, 3));
            write_data_i   = 16'($urandom);
            tick;
        end
        chk("reset_tx", 16'(tx_o), 16'h0001);
        chk("reset_irq", 16'(irq_o), 16'h0001);
        chk("reset_read_data", read_data_o, 16'h0000);
        select_i = 1'b0; read_enable_i = 1'b0; write_enable_i = 1'b0;
        rst_ni = 1'b1;
        tick;

        foreach (tbl[i]) begin
            bus(tbl[i].wr, tbl[i].sel, tbl[i].addr, tbl[i].data);
            chk($sformatf("regvec%0d", i), read_data_o, tbl[i].exp);
        end

        // Single byte at D=4.
        start_q.delete();
        expect_frame(8'hA5, 4);
        bus(1'b1, 1'b1, 16'hFF00, 16'h00A5);
        c0 = cyc;
        chk("single_irq_falls_at_push", 16'(irq_o), 16'h0000);
        chk("single_tx_idle_after_push", 16'(tx_o), 16'h0001);
        wait_cyc(c0 + 41);
        chk("single_irq_low_in_stop", 16'(irq_o), 16'h0000);
        tick;
        chk("single_irq_rises", 16'(irq_o), 16'h0001);
        chk("single_tx_idle_after", 16'(tx_o), 16'h0001);
        drain("single");
        lat = (start_q.size() == 1) ? start_q[0] - c0 : -1;
        chk("single_start_latency", 16'(lat), 16'd2);

        // Burst of ten writes: 0x01 popped early, 0x02..0x09 fill the FIFO, 0x0A overflows.
        start_q.delete();
        for (int b = 1; b <= 9; b++) expect_frame(8'(b), 4);
        for (int b = 1; b <= 10; b++) begin
            bus(1'b1, 1'b1, 16'hFF00, 16'(b));
            if (b == 1) c0 = cyc;
        end
        bus(1'b0, 1'b1, 16'hFF01, 16'h0000);
        chk("burst_status_full_ovf", read_data_o, 16'h008D);
        bus(1'b0, 1'b1, 16'hFF01, 16'h0000);
        chk("burst_status_ovf_cleared", read_data_o, 16'h0085);
        chk("burst_irq_low", 16'(irq_o), 16'h0000);
        // Push lands on the same edge the FSM pops with count=8: dropped, overflow set.
        wait_cyc(c0 + 41);
        bus(1'b1, 1'b1, 16'hFF00, 16'h000B);
        bus(1'b0, 1'b1, 16'hFF01, 16'h0000);
        chk("pop_push_full_status", read_data_o, 16'h007C);
        drain("burst");
        chk_gaps("burst", 9, 41);
        bus(1'b0, 1'b1, 16'hFF01, 16'h0000);
        chk("burst_status_done", read_data_o, 16'h0002);
        chk("burst_irq_done", 16'(irq_o), 16'h0001);

        // Push and pop on the same edge with count=3 at D=2.
        bus(1'b1, 1'b1, 16'hFF02, 16'h0002);
        start_q.delete();
        for (int b = 1; b <= 5; b++) expect_frame(8'(b * 17), 2);
        for (int b = 1; b <= 4; b++) begin
            bus(1'b1, 1'b1, 16'hFF00, 16'(b * 17));
            if (b == 1) c0 = cyc;
        end
        wait_cyc(c0 + 21);
        bus(1'b1, 1'b1, 16'hFF00, 16'h0055);
        bus(1'b0, 1'b1, 16'hFF01, 16'h0000);
        chk("pop_push_cnt3_status", read_data_o, 16'h0034);
        drain("cnt3");
        chk_gaps("cnt3", 5, 21);

        // Divisor change mid-frame takes effect at the next frame.
        bus(1'b1, 1'b1, 16'hFF02, 16'h0004);
        start_q.delete();
        expect_frame(8'hC3, 4);
        expect_frame(8'h3C, 2);
        bus(1'b1, 1'b1, 16'hFF00, 16'h00C3);
        bus(1'b1, 1'b1, 16'hFF00, 16'h003C);
        bus(1'b1, 1'b1, 16'hFF02, 16'h0002);
        drain("divchg");
        chk_gaps("divchg", 2, 41);

        // DIVISOR=0 runs at one cycle per bit; the register still reads back 0.
        bus(1'b1, 1'b1, 16'hFF02, 16'h0000);
        start_q.delete();
        expect_frame(8'h5A, 1);
        bus(1'b1, 1'b1, 16'hFF00, 16'h005A);
        drain("div0");
        chk_gaps("div0", 1, 0);
        bus(1'b0, 1'b1, 16'hFF02, 16'h0000);
        chk("div0_readback", read_data_o, 16'h0000);

        // Reset asserted during data bit 3 of 0x00.
        bus(1'b1, 1'b1, 16'hFF02, 16'h0004);
        expect_frame(8'h00, 4);
        bus(1'b1, 1'b1, 16'hFF00, 16'h0000);
        c0 = cyc;
        wait_cyc(c0 + 19);
        chk("midframe_tx_bit3", 16'(tx_o), 16'h0000);
        rst_ni = 1'b0;
        #1;
        chk("midframe_tx_async_high", 16'(tx_o), 16'h0001);
        chk("midframe_irq_async_high", 16'(irq_o), 16'h0001);
        tick; tick; tick;
        rst_ni = 1'b1;
        tick;
        bus(1'b0, 1'b1, 16'hFF01, 16'h0000);
        chk("midframe_status_after", read_data_o, 16'h0002);
        bus(1'b0, 1'b1, 16'hFF02, 16'h0000);
        chk("midframe_divisor_reset", read_data_o, 16'h0068);
        for (int i = 0; i < 60; i++) tick;
        chk("midframe_tx_idle", 16'(tx_o), 16'h0001);
        chk("midframe_irq_idle", 16'(irq_o), 16'h0001);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
